// File: rtl/apu_frame_sequencer_pkg.sv
// APU frame-sequencer shared constants.
// NTSC step timing, mode encodings and $4017 bit positions.
package apu_frame_sequencer_pkg;

    localparam int NTSC_STEP1 = 7457;
    localparam int NTSC_STEP2 = 14913;
    localparam int NTSC_STEP3 = 22371;
    localparam int NTSC_STEP4 = 29829;
    localparam int NTSC_STEP5 = 37281;

    localparam logic MODE_4STEP = 1'b0;
    localparam logic MODE_5STEP = 1'b1;

    localparam int MODE_BIT    = 7;
    localparam int INHIBIT_BIT = 6;

endpackage

// File: rtl/apu_frame_sequencer_if.sv
// Frame-sequencer bus: CPU tick, $4017 write, IRQ ack in;
// quarter/half clocks, IRQ and mode out.
interface apu_frame_sequencer_if;

    logic       iEnable;
    logic       iWrite;
    logic [7:0] iData;
    logic       iIrq_ack;
    logic       oQuarter_clk;
    logic       oHalf_clk;
    logic       oIrq;
    logic       oMode;

    modport master (
        input  iEnable,
        input  iWrite,
        input  iData,
        input  iIrq_ack,
        output oQuarter_clk,
        output oHalf_clk,
        output oIrq,
        output oMode
    );

    modport slave (
        output iEnable,
        output iWrite,
        output iData,
        output iIrq_ack,
        input  oQuarter_clk,
        input  oHalf_clk,
        input  oIrq,
        input  oMode
    );

endinterface

// File: rtl/apu_frame_sequencer.sv
// APU frame sequencer: cycle counter, step decode and frame IRQ.
// Emits one-iClk quarter/half strobes in 4-step or 5-step mode.
module apu_frame_sequencer
    import apu_frame_sequencer_pkg::*;
#(
    parameter int CNT_WIDTH = 16,
    parameter int STEP1     = NTSC_STEP1,
    parameter int STEP2     = NTSC_STEP2,
    parameter int STEP3     = NTSC_STEP3,
    parameter int STEP4     = NTSC_STEP4,
    parameter int STEP5     = NTSC_STEP5
) (
    input  logic                  iClk,
    input  logic                  iReset,
    apu_frame_sequencer_if.master bus
);

    localparam logic [CNT_WIDTH-1:0] L_S1 = CNT_WIDTH'(STEP1);
    localparam logic [CNT_WIDTH-1:0] L_S2 = CNT_WIDTH'(STEP2);
    localparam logic [CNT_WIDTH-1:0] L_S3 = CNT_WIDTH'(STEP3);
    localparam logic [CNT_WIDTH-1:0] L_S4 = CNT_WIDTH'(STEP4);
    localparam logic [CNT_WIDTH-1:0] L_S5 = CNT_WIDTH'(STEP5);

    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_mode;
    logic                 r_inhibit;
    logic                 r_irq;
    logic                 r_q;
    logic                 r_h;

    logic [CNT_WIDTH-1:0] w_nxt;
    logic                 w_five;
    logic                 w_end;
    logic                 w_unused;

    assign w_nxt    = r_cnt + CNT_WIDTH'(1);
    assign w_five   = (r_mode == MODE_5STEP);
    assign w_end    = w_five ? (w_nxt == L_S5) : (w_nxt == L_S4);
    assign w_unused = &{1'b0, bus.iData[5:0]};

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            r_cnt     <= '0;
            r_mode    <= MODE_4STEP;
            r_inhibit <= 1'b0;
            r_irq     <= 1'b0;
            r_q       <= 1'b0;
            r_h       <= 1'b0;
        end else begin
            r_q <= 1'b0;
            r_h <= 1'b0;
            // ack clears first so a same-edge step-4 set wins
            if (bus.iIrq_ack)
                r_irq <= 1'b0;
            if (bus.iWrite) begin
                r_mode    <= bus.iData[MODE_BIT];
                r_inhibit <= bus.iData[INHIBIT_BIT];
                r_cnt     <= '0;
                if (bus.iData[INHIBIT_BIT])
                    r_irq <= 1'b0;
                if (bus.iData[MODE_BIT]) begin
                    r_q <= 1'b1;
                    r_h <= 1'b1;
                end
            end else if (bus.iEnable) begin
                r_cnt <= w_end ? '0 : w_nxt;
                unique case (1'b1)
                    (w_nxt == L_S1),
                    (w_nxt == L_S3): r_q <= 1'b1;
                    (w_nxt == L_S2): begin
                        r_q <= 1'b1;
                        r_h <= 1'b1;
                    end
                    (w_nxt == L_S4 && !w_five): begin
                        r_q <= 1'b1;
                        r_h <= 1'b1;
                        if (!r_inhibit)
                            r_irq <= 1'b1;
                    end
                    (w_nxt == L_S5 && w_five): begin
                        r_q <= 1'b1;
                        r_h <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.oQuarter_clk = r_q;
    assign bus.oHalf_clk    = r_h;
    assign bus.oIrq         = r_irq;
    assign bus.oMode        = r_mode;

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Randomized bench for apu_frame_sequencer against a
// sequence-table reference model, with small step values.
module tb_apu_frame_sequencer;

    localparam int W  = 16;
    localparam int S1 = 4;
    localparam int S2 = 8;
    localparam int S3 = 12;
    localparam int S4 = 16;
    localparam int S5 = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    apu_frame_sequencer_if bus ();

    apu_frame_sequencer #(
        .CNT_WIDTH(W),
        .STEP1(S1), .STEP2(S2), .STEP3(S3),
        .STEP4(S4), .STEP5(S5)
    ) dut (
        .iClk(clk),
        .iReset(rst),
        .bus(bus)
    );

    initial begin
        if (!(S1 < S2 && S2 < S3 && S3 < S4 && S4 < S5 && S5 < (1 << W)))
            $fatal(1, "FAIL step_order: steps not strictly increasing within width");
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Each mode is a list of four quarter events; every second one is
    // also a half event, and the last one ends the sequence.
    int  seq_q [2][4] = '{'{S1, S2, S3, S4}, '{S1, S2, S3, S5}};
    int  m_cnt;
    bit  m_mode, m_inh, m_irq, m_q, m_h;

    task automatic model_reset();
        m_cnt = 0; m_mode = 0; m_inh = 0; m_irq = 0; m_q = 0; m_h = 0;
    endtask

    task automatic model_step(input bit en, input bit wr, input bit ack,
                              input logic [7:0] d);
        int n;
        m_q = 0;
        m_h = 0;
        if (ack) m_irq = 0;
        if (wr) begin
            m_mode = d[7];
            m_inh  = d[6];
            m_cnt  = 0;
            if (d[6]) m_irq = 0;
            if (d[7]) begin m_q = 1; m_h = 1; end
        end else if (en) begin
            n = m_cnt + 1;
            m_cnt = n;
            for (int k = 0; k < 4; k++) begin
                if (n == seq_q[m_mode][k]) begin
                    m_q = 1;
                    m_h = (k % 2 == 1);
                    if (k == 3) begin
                        m_cnt = 0;
                        if (!m_mode && !m_inh) m_irq = 1;
                    end
                end
            end
        end
    endtask

    task automatic check_all(input string pfx);
        check_eq({pfx, "_quarter"}, 32'(bus.oQuarter_clk), 32'(m_q));
        check_eq({pfx, "_half"},    32'(bus.oHalf_clk),    32'(m_h));
        check_eq({pfx, "_irq"},     32'(bus.oIrq),         32'(m_irq));
        check_eq({pfx, "_mode"},    32'(bus.oMode),        32'(m_mode));
    endtask

    // At a negedge: check outputs, drive next inputs, advance the model.
    task automatic cycle(input bit en, input bit wr, input bit ack,
                         input logic [7:0] d);
        @(negedge clk);
        check_all("cyc");
        bus.iEnable  = en;
        bus.iWrite   = wr;
        bus.iIrq_ack = ack;
        bus.iData    = d;
        model_step(en, wr, ack, d);
    endtask

    task automatic run(input int n, input int en_div, input int wr_pm,
                       input int ack_pm);
        bit en, wr, ack;
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            en  = ($urandom_range(en_div - 1) == 0);
            wr  = ($urandom_range(999) < wr_pm);
            ack = ($urandom_range(999) < ack_pm);
            d   = 8'($urandom);
            cycle(en, wr, ack, d);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus.iEnable = 0; bus.iWrite = 0; bus.iIrq_ack = 0; bus.iData = '0;
        #1;
        model_reset();
        check_all("rst");
        @(negedge clk);
        check_all("rst_hold");
        rst = 1'b0;
    endtask

    initial begin
        bus.iEnable = 0; bus.iWrite = 0; bus.iIrq_ack = 0; bus.iData = '0;
        model_reset();
        repeat (2) @(negedge clk);
        apply_reset();

        run(40, 1, 0, 0);
        cycle(1, 1, 0, 8'h80);
        run(60, 1, 0, 0);
        cycle(1, 1, 0, 8'h00);
        run(20, 1, 0, 0);
        cycle(1, 1, 0, 8'h40);
        run(40, 1, 0, 0);
        cycle(0, 1, 0, 8'h00);

        // ack exactly on the step-4 tick, then ack again
        run(15, 1, 0, 0);
        cycle(1, 0, 1, 8'h00);
        cycle(1, 0, 1, 8'h00);
        run(10, 1, 0, 0);

        run(120, 3, 0, 0);
        run(3000, 1, 8, 30);
        run(3000, 3, 8, 30);
        run(3000, 2, 20, 60);

        // drive to the start of a quarter pulse, then reset mid-pulse
        cycle(1, 1, 0, 8'h00);
        begin : find_q
            bit found = 0;
            for (int i = 0; i < 200 && !found; i++) begin
                cycle(1, 0, 0, 8'h00);
                if (m_q) found = 1;
            end
            check_eq("q_pulse_found", 32'(found), 32'd1);
        end
        @(posedge clk);
        #2;
        check_eq("pre_rst_quarter", 32'(bus.oQuarter_clk), 32'd1);
        apply_reset();
        run(40, 1, 0, 0);
        run(200, 3, 0, 0);
        @(negedge clk);
        check_all("end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
